// File: rtl/lc3_agu_pkg.sv
// Shared encodings and helpers for the LC-3 effective-address generation unit.
package lc3_agu_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_OUT      = 2'd1;
    localparam logic [1:0] ST_IND_REQ  = 2'd2;
    localparam logic [1:0] ST_IND_WAIT = 2'd3;

    localparam logic [1:0] SEL_ZERO  = 2'b00;
    localparam logic [1:0] SEL_OFF6  = 2'b01;
    localparam logic [1:0] SEL_OFF9  = 2'b10;
    localparam logic [1:0] SEL_OFF11 = 2'b11;

    // Sign-extends the low src_w bits of val to 16 bits, using bit src_w-1 as the sign.
    function automatic logic [15:0] sext(input logic [15:0] val, input int src_w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = (i < src_w) ? val[i] : val[src_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/lc3_agu_calc.sv
// Combinational base + sign-extended offset adder; the wrap compare exists only
// when LC3_AGU_WRAP_CHK_EN is defined.
module lc3_agu_calc
    import lc3_agu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              addr1_sel,
    input  logic [1:0]        addr2_sel,
    input  logic [10:0]       ir_off,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] sr1,
`ifdef LC3_AGU_WRAP_CHK_EN
    output logic              wrap,
`endif
    output logic [ADDR_W-1:0] sum
);

    logic [ADDR_W-1:0]  base;
    logic signed [15:0] off16;

    always_comb begin
        base  = addr1_sel ? sr1 : pc;
        off16 = '0;
        case (addr2_sel)
            SEL_OFF6:  off16 = sext({5'b0, ir_off}, 6);
            SEL_OFF9:  off16 = sext({5'b0, ir_off}, 9);
            SEL_OFF11: off16 = sext({5'b0, ir_off}, 11);
            default:   off16 = '0;
        endcase
    end

    assign sum = base + ADDR_W'(off16);

`ifdef LC3_AGU_WRAP_CHK_EN
    logic [ADDR_W:0] wide;

    // With the base zero-extended, bit ADDR_W is set both for a negative result and an overflow.
    assign wide = {1'b0, base} + (ADDR_W+1)'(off16);
    assign wrap = wide[ADDR_W];
`endif

endmodule

// File: rtl/lc3_agu.sv
// Handshaked LC-3 address generation unit with optional indirect pointer fetch.
// Optional wrap detection enabled by defining LC3_AGU_WRAP_CHK_EN.
module lc3_agu
    import lc3_agu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_addr1_sel,
    input  logic [1:0]        req_addr2_sel,
    input  logic              req_indirect,
    input  logic [15:0]       req_ir,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic [ADDR_W-1:0] req_sr1,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [ADDR_W-1:0] mem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              out_wrap
);

    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sum;
    logic              err_q;
    logic [31:0]       wait_cnt;
    logic              accept;
    logic              timeout_hit;

    assign req_ready     = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
    assign accept        = req_valid && req_ready;
    assign timeout_hit   = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
    assign mem_req_valid = (state == ST_IND_REQ);
    assign out_valid     = (state == ST_OUT);
    assign out_err       = err_q;

    // One address register serves as pointer address and as final result,
    // so a timed-out fetch naturally reports the pointer address.
    assign mem_req_addr  = addr_q;
    assign out_addr      = addr_q;

`ifdef LC3_AGU_WRAP_CHK_EN
    logic calc_wrap;
    logic wrap_q;

    lc3_agu_calc #(.ADDR_W(ADDR_W)) u_calc (
        .addr1_sel (req_addr1_sel),
        .addr2_sel (req_addr2_sel),
        .ir_off    (req_ir[10:0]),
        .pc        (req_pc),
        .sr1       (req_sr1),
        .wrap      (calc_wrap),
        .sum       (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else if (accept) begin
            wrap_q <= calc_wrap;
        end
    end

    assign out_wrap = wrap_q;
`else
    lc3_agu_calc #(.ADDR_W(ADDR_W)) u_calc (
        .addr1_sel (req_addr1_sel),
        .addr2_sel (req_addr2_sel),
        .ir_off    (req_ir[10:0]),
        .pc        (req_pc),
        .sr1       (req_sr1),
        .sum       (sum)
    );

    assign out_wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else if (accept) begin
            addr_q <= sum;
            err_q  <= 1'b0;
            state  <= req_indirect ? ST_IND_REQ : ST_OUT;
        end else begin
            case (state)
                ST_OUT: begin
                    if (out_ready) state <= ST_IDLE;
                end
                ST_IND_REQ: begin
                    if (mem_req_ready) begin
                        state    <= ST_IND_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_IND_WAIT: begin
                    // A response arriving on the timeout cycle takes priority.
                    if (mem_rsp_valid) begin
                        addr_q <= mem_rsp_data;
                        err_q  <= 1'b0;
                        state  <= ST_OUT;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= ST_OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_agu.sv
// Directed self-checking bench for lc3_agu (TIMEOUT = 8); wrap expectations follow LC3_AGU_WRAP_CHK_EN.
module tb_lc3_agu;

`ifdef LC3_AGU_WRAP_CHK_EN
    localparam logic WRAP_ON = 1'b1;
`else
    localparam logic WRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_addr1_sel;
    logic [1:0]  req_addr2_sel;
    logic        req_indirect;
    logic [15:0] req_ir;
    logic [15:0] req_pc;
    logic [15:0] req_sr1;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_addr;
    logic        out_err;
    logic        out_wrap;

    int checks = 0;
    int fails  = 0;

    lc3_agu #(.ADDR_W(16), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr1_sel (req_addr1_sel),
        .req_addr2_sel (req_addr2_sel),
        .req_indirect  (req_indirect),
        .req_ir        (req_ir),
        .req_pc        (req_pc),
        .req_sr1       (req_sr1),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_err       (out_err),
        .out_wrap      (out_wrap)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic sel1, input logic [1:0] sel2, input logic ind,
                                 input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] sr1);
        req_valid     = 1'b1;
        req_addr1_sel = sel1;
        req_addr2_sel = sel2;
        req_indirect  = ind;
        req_ir        = ir;
        req_pc        = pc;
        req_sr1       = sr1;
    endtask

    task automatic sendDirect(input string tag, input logic sel1, input logic [1:0] sel2,
                              input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] sr1,
                              input logic [15:0] exp_addr, input logic exp_wrap);
        applyStimulus(sel1, sel2, 1'b0, ir, pc, sr1);
        tick();
        req_valid = 1'b0;
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
        checkOutput({tag, "_err"}, 32'(out_err), 32'd0);
        checkOutput({tag, "_wrap"}, 32'(out_wrap), 32'(exp_wrap));
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr1_sel = 1'b0; req_addr2_sel = 2'b00; req_indirect = 1'b0;
        req_ir = '0; req_pc = '0; req_sr1 = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        out_ready = 1'b1;

        #12;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
        checkOutput("rst_out_wrap", 32'(out_wrap), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        sendDirect("pc_off9", 1'b0, 2'b10, 16'h01FF, 16'h3000, 16'h0000, 16'h2FFF, 1'b0);
        sendDirect("off9_bit5", 1'b0, 2'b10, 16'h0020, 16'h3000, 16'h0000, 16'h3020, 1'b0);
        sendDirect("sr1_off6_neg", 1'b1, 2'b01, 16'h0020, 16'h0000, 16'h4000, 16'h3FE0, 1'b0);
        sendDirect("sr1_off6_pos", 1'b1, 2'b01, 16'h001F, 16'h0000, 16'h4000, 16'h401F, 1'b0);
        sendDirect("sr1_zero", 1'b1, 2'b00, 16'hFFFF, 16'h0000, 16'h4000, 16'h4000, 1'b0);
        sendDirect("off11_min", 1'b0, 2'b11, 16'h0400, 16'h1000, 16'h0000, 16'h0C00, 1'b0);
        sendDirect("off11_m1", 1'b0, 2'b11, 16'h07FF, 16'h0005, 16'h0000, 16'h0004, 1'b0);
        sendDirect("wrap_up", 1'b0, 2'b11, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, WRAP_ON);
        sendDirect("wrap_down", 1'b0, 2'b01, 16'h003F, 16'h0000, 16'h0000, 16'hFFFF, WRAP_ON);

        // Indirect fetch with delayed mem_req_ready and a stray response during IND_REQ
        mem_req_ready = 1'b0;
        applyStimulus(1'b0, 2'b10, 1'b1, 16'h0010, 16'h3000, 16'h0000);
        tick();
        req_valid = 1'b0;
        checkOutput("ind_req_valid", 32'(mem_req_valid), 32'd1);
        checkOutput("ind_req_addr", 32'(mem_req_addr), 32'h3010);
        checkOutput("ind_no_out", 32'(out_valid), 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'hDEAD;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("ind_req_hold", 32'(mem_req_valid), 32'd1);
        checkOutput("ind_req_addr_hold", 32'(mem_req_addr), 32'h3010);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("ind_wait_no_req", 32'(mem_req_valid), 32'd0);
        checkOutput("ind_wait_no_out", 32'(out_valid), 32'd0);
        tick();
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h5000;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("ind_out_valid", 32'(out_valid), 32'd1);
        checkOutput("ind_out_addr", 32'(out_addr), 32'h5000);
        checkOutput("ind_out_err", 32'(out_err), 32'd0);
        tick();

        // Backpressure then back-to-back accept
        out_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h0000, 16'h1234, 16'h0000);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_addr", 32'(out_addr), 32'h1234);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        applyStimulus(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h4000);
        #1;
        checkOutput("b2b_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("b2b_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_addr", 32'(out_addr), 32'h4000);
        tick();

        // Timeout with no response
        mem_req_ready = 1'b1;
        applyStimulus(1'b0, 2'b10, 1'b1, 16'h0010, 16'h3000, 16'h0000);
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        repeat (7) tick();
        checkOutput("to_not_yet", 32'(out_valid), 32'd0);
        tick();
        checkOutput("to_valid", 32'(out_valid), 32'd1);
        checkOutput("to_err", 32'(out_err), 32'd1);
        checkOutput("to_addr", 32'(out_addr), 32'h3010);
        tick();

        // Response on the timeout cycle wins
        mem_req_ready = 1'b1;
        applyStimulus(1'b0, 2'b10, 1'b1, 16'h0010, 16'h3000, 16'h0000);
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        repeat (7) tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h6000;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("to_rsp_valid", 32'(out_valid), 32'd1);
        checkOutput("to_rsp_err", 32'(out_err), 32'd0);
        checkOutput("to_rsp_addr", 32'(out_addr), 32'h6000);
        tick();

        // Reset during IND_WAIT, then a late response
        mem_req_ready = 1'b1;
        applyStimulus(1'b0, 2'b10, 1'b1, 16'h0010, 16'h3000, 16'h0000);
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mrst_mem_req", 32'(mem_req_valid), 32'd0);
        checkOutput("mrst_out_addr", 32'(out_addr), 32'd0);
        checkOutput("mrst_out_err", 32'(out_err), 32'd0);
        #1;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h7777;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("late_rsp_valid", 32'(out_valid), 32'd0);
        checkOutput("late_rsp_addr", 32'(out_addr), 32'd0);
        checkOutput("late_rsp_ready", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
